vram_arbiter: RTL and testbench

Arbitrates a single-port synchronous pixel memory (RGB565, 800x480) between display scan-out and a pixel writer. A small prefetch FIFO is kept ahead of the 800x480 timing generator's pixel strobe, and every spare memory cycle goes to the writer. The block sits between the timing generator, the drawing/CPU write path and the VRAM macro, and runs at the 100 MHz system clock.

---
 rtl/vram_pkg.sv | 25 ++
 rtl/pix_fifo.sv | 66 ++++++
 rtl/vram_arbiter.sv | 122 ++++++++++++
 tb/tb_vram_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
`timescale 1ns/1ps
// Shared widths, frame geometry and FSM encoding for the VRAM arbiter.
package vram_pkg;

  localparam int unsigned AW          = 19;
  localparam int unsigned DW          = 16;
  localparam int unsigned H_ACTIVE    = 800;
  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned FRAME_WORDS = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // One memory access as presented on the o_mem_* port.
  typedef struct packed {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/pix_fifo.sv
`timescale 1ns/1ps
// Prefetch FIFO for scan-out pixels with a registered head word.
// Ports: clk/rst_n, push+wdata, pop, flush (clears contents, dominates
// push/pop), head (current front pixel, held when empty), count.
module pix_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 16,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [W-1:0]  head_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush && (count_q != CW'(DEPTH));
  assign do_pop  = pop && !flush && (count_q != '0);
  assign head    = head_q;
  assign count   = count_q;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      // Head follows the next stored entry, or bypasses the pushed word when
      // it becomes the only entry; it keeps its last value once drained.
      if (do_pop) begin
        if (count_q > CW'(1))  head_q <= mem[rd_ptr + PW'(1)];
        else if (do_push)      head_q <= wdata;
      end else if (do_push && (count_q == '0)) begin
        head_q <= wdata;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
// Single-port VRAM arbiter: keeps a scan-out prefetch FIFO topped up and
// hands every spare memory cycle to the pixel writer.
// Ports: i_clk/i_rst_n; i_frame_start restarts the frame fetch; i_pix_rd pops
// o_pix/o_pix_valid, o_underrun is sticky; i_wr_* / o_wr_ready is the writer
// handshake; o_mem_* / i_mem_rdata drive the memory (1-cycle read latency).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = vram_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE   = vram_pkg::V_ACTIVE,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LOW_WATER  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_frame_start,
  input  logic          i_pix_rd,
  output logic [DW-1:0] o_pix,
  output logic          o_pix_valid,
  output logic          o_underrun,
  input  logic          i_wr_valid,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_wr_ready,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam int unsigned FRAME = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LW    = CW + 1;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          inflight_q;
  logic          active_q;
  logic          underrun_q;
  logic [CW-1:0] count;
  logic [LW-1:0] level;
  logic          need;
  logic          urgent;
  logic          rd_grant;
  logic          wr_grant;
  mem_req_t      req;

  // Occupancy including the read whose data is still on its way back.
  assign level    = LW'(count) + LW'(inflight_q);
  assign need     = (state_q == S_RUN) && (level < LW'(FIFO_DEPTH));
  assign urgent   = need && (level < LW'(LOW_WATER));
  assign rd_grant = need && !i_frame_start && (urgent || !i_wr_valid);
  // active_q keeps the writer off the bus until the first edge after reset.
  assign wr_grant = active_q && i_wr_valid && !rd_grant;

  // Next-state, fetch address and memory command.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    req       = '0;
    if (rd_grant) begin
      req.en    = 1'b1;
      req.addr  = rd_addr_q;
      rd_addr_d = rd_addr_q + AW'(1);
      if (rd_addr_q == AW'(FRAME - 1)) state_d = S_DONE;
    end else if (wr_grant) begin
      req.en    = 1'b1;
      req.we    = 1'b1;
      req.addr  = i_wr_addr;
      req.wdata = i_wr_data;
    end
    if (i_frame_start) begin
      state_d   = S_RUN;
      rd_addr_d = '0;
    end
  end

  assign o_mem_en    = req.en;
  assign o_mem_we    = req.we;
  assign o_mem_addr  = req.addr;
  assign o_mem_wdata = req.wdata;
  assign o_wr_ready  = wr_grant;

  // State, fetch pointer, in-flight marker and sticky underrun.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      active_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= rd_grant;
      active_q   <= 1'b1;
      if (i_pix_rd && (count == '0) && !i_frame_start) underrun_q <= 1'b1;
    end
  end

  assign o_underrun  = underrun_q;
  assign o_pix_valid = (count != '0);

  // A frame start discards the returning read by flushing in the same edge.
  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DW),
    .CW    (CW)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (inflight_q && !i_frame_start),
    .wdata (i_mem_rdata),
    .pop   (i_pix_rd),
    .flush (i_frame_start),
    .head  (o_pix),
    .count (count)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for vram_arbiter using a reduced 40x25 frame.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int unsigned TH = 40;
  localparam int unsigned TV = 25;
  localparam int unsigned TF = TH * TV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_rd = 1'b0;
  logic [DW-1:0] pix;
  logic          pix_valid;
  logic          underrun;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0]    pixq [$];
  logic [AW+DW-1:0] wq [$];
  logic [AW-1:0]    rd_next;

  vram_arbiter #(.H_ACTIVE(TH), .V_ACTIVE(TV), .FIFO_DEPTH(8), .LOW_WATER(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame_start (frame_start),
    .i_pix_rd      (pix_rd),
    .o_pix         (pix),
    .o_pix_valid   (pix_valid),
    .o_underrun    (underrun),
    .i_wr_valid    (wr_valid),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .o_wr_ready    (wr_ready),
    .o_mem_en      (mem_en),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: mem[a] = a[15:0], one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr[15:0];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic test_reset;
    rst_n = 1'b0; wr_valid = 1'b1; wr_addr = 19'h00123; wr_data = 16'hABCD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, wr_ready, pix_valid, underrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got en/we/rdy/val/unr=%b expected 00000",
               {mem_en, mem_we, wr_ready, pix_valid, underrun});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || pix !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h pix=%h expected all 0", mem_addr, mem_wdata, pix);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (mem_en !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got en=%b rdy=%b expected 0 0 before next edge", mem_en, wr_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'h00123) begin
      errors++;
      $display("FAIL reset_first_grant: got rdy=%b we=%b addr=%h expected 1 1 00123", wr_ready, mem_we, mem_addr);
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_idle_writes;
    logic [AW+DW-1:0] want;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 16'hF800;
      wq.push_back({wr_addr, wr_data});
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1) begin
        errors++;
        $display("FAIL idle_write_grant[%0d]: got rdy=%b en=%b we=%b expected 1 1 1", i, wr_ready, mem_en, mem_we);
      end
      want = wq.pop_front();
      checks++;
      if ({mem_addr, mem_wdata} !== want) begin
        errors++;
        $display("FAIL idle_write_data[%0d]: got %h/%h expected %h", i, mem_addr, mem_wdata, want);
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_fill;
    int reads;
    logic [DW-1:0] want;
    reads = 0; rd_next = '0; pixq.delete();
    frame_start = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0) begin
      errors++;
      $display("FAIL fill_fs_cycle: got mem_en=%b expected 0", mem_en);
    end
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_en === 1'b1 && mem_we === 1'b0) begin
        checks++;
        if (mem_addr !== rd_next || k > 8) begin
          errors++;
          $display("FAIL fill_read: cycle f+%0d got addr=%h expected %h within f+1..f+8", k, mem_addr, rd_next);
        end
        pixq.push_back(rd_next[15:0]); rd_next++; reads++;
      end
      if (k == 2) begin
        checks++;
        if (pix_valid !== 1'b0) begin
          errors++;
          $display("FAIL fill_valid_early: got %b expected 0 at f+2", pix_valid);
        end
      end
      if (k == 3) begin
        checks++;
        if (pix_valid !== 1'b1 || pix !== 16'h0000) begin
          errors++;
          $display("FAIL fill_first_pixel: got valid=%b pix=%h expected 1 0000 at f+3", pix_valid, pix);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (reads != 8) begin
      errors++;
      $display("FAIL fill_read_count: got %0d expected 8", reads);
    end
    for (int p = 0; p < 3; p++) begin
      pix_rd = 1'b1;
      @(negedge clk);
      want = (pixq.size() > 0) ? pixq.pop_front() : 16'hxxxx;
      checks++;
      if (pix !== want) begin
        errors++;
        $display("FAIL fill_pop[%0d]: got %h expected %h", p, pix, want);
      end
      if (mem_en === 1'b1 && mem_we === 1'b0) begin
        pixq.push_back(rd_next[15:0]); rd_next++;
      end
      @(posedge clk); #1;
    end
    pix_rd = 1'b0;
    @(negedge clk);
    checks++;
    if (pix !== 16'h0003) begin
      errors++;
      $display("FAIL fill_after_3_pops: got %h expected 0003", pix);
    end
    if (mem_en === 1'b1 && mem_we === 1'b0) begin
      pixq.push_back(rd_next[15:0]); rd_next++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    bit found;
    logic [DW-1:0] want;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      pix_rd = pix_valid;
      @(negedge clk);
      if (pix_rd) begin
        want = (pixq.size() > 0) ? pixq.pop_front() : 16'hxxxx;
        checks++;
        if (pix !== want) begin
          errors++;
          $display("FAIL flush_pop: got %h expected %h", pix, want);
        end
      end
      if (mem_en === 1'b1 && mem_we === 1'b0) begin
        checks++;
        if (mem_addr !== rd_next) begin
          errors++;
          $display("FAIL flush_read_seq: got addr=%h expected %h", mem_addr, rd_next);
        end
        if (mem_addr == 19'd100) found = 1'b1;
        pixq.push_back(rd_next[15:0]); rd_next++;
      end
      @(posedge clk); #1;
    end
    pix_rd = 1'b0;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL flush_setup: got no read to addr 100 expected one within 300 cycles");
    end
    frame_start = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_fs_cycle: got mem_en=%b expected 0", mem_en);
    end
    @(posedge clk); #1;
    frame_start = 1'b0; pixq.delete(); rd_next = '0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) begin
        checks++;
        if (pix_valid !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0) begin
          errors++;
          $display("FAIL flush_restart: got valid=%b en=%b we=%b addr=%h expected 0 1 0 0",
                   pix_valid, mem_en, mem_we, mem_addr);
        end
      end
      if (k == 3) begin
        checks++;
        if (pix_valid !== 1'b0) begin
          errors++;
          $display("FAIL flush_stale_push: got valid=%b expected 0", pix_valid);
        end
      end
      if (k == 4) begin
        checks++;
        if (pix_valid !== 1'b1 || pix !== 16'h0000) begin
          errors++;
          $display("FAIL flush_new_head: got valid=%b pix=%h expected 1 0000", pix_valid, pix);
        end
      end
      if (mem_en === 1'b1 && mem_we === 1'b0) begin
        pixq.push_back(rd_next[15:0]); rd_next++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention;
    int cyc, pops, writes, reads, bad_done;
    bit acc;
    logic [AW-1:0] waddr;
    logic [AW+DW-1:0] want;
    logic [DW-1:0] wpix;
    frame_start = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    frame_start = 1'b0; pixq.delete(); wq.delete(); rd_next = '0;
    waddr = 19'h40000;
    wr_valid = 1'b1; wr_addr = waddr; wr_data = 16'($urandom);
    wq.push_back({wr_addr, wr_data});
    cyc = 1; pops = 0; writes = 0; reads = 0;
    while (pops < int'(TF) && cyc < 4 * int'(TF) + 400) begin
      pix_rd = (cyc % 4 == 0);
      @(negedge clk);
      if (pix_rd) begin
        pops++;
        wpix = (pixq.size() > 0) ? pixq.pop_front() : 16'hxxxx;
        checks++;
        if (pix !== wpix) begin
          errors++;
          $display("FAIL cont_pixel[%0d]: got %h expected %h", pops, pix, wpix);
        end
      end
      if (mem_en === 1'b1 && mem_we === 1'b0) begin
        checks++;
        if (mem_addr !== rd_next) begin
          errors++;
          $display("FAIL cont_read_seq: got addr=%h expected %h", mem_addr, rd_next);
        end
        pixq.push_back(rd_next[15:0]); rd_next++; reads++;
      end
      acc = (wr_ready === 1'b1);
      if (acc) begin
        want = wq.pop_front();
        checks++;
        if (mem_we !== 1'b1 || {mem_addr, mem_wdata} !== want) begin
          errors++;
          $display("FAIL cont_write: got we=%b %h/%h expected 1 %h", mem_we, mem_addr, mem_wdata, want);
        end
        writes++;
      end
      @(posedge clk); #1;
      if (acc) begin
        waddr++; wr_addr = waddr; wr_data = 16'($urandom);
        wq.push_back({wr_addr, wr_data});
      end
      cyc++;
    end
    pix_rd = 1'b0;
    checks++;
    if (pops != int'(TF)) begin
      errors++;
      $display("FAIL cont_pops: got %0d expected %0d within cycle budget", pops, TF);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL cont_underrun: got %b expected 0", underrun);
    end
    checks++;
    if (reads != int'(TF)) begin
      errors++;
      $display("FAIL cont_reads: got %0d expected %0d", reads, TF);
    end
    checks++;
    if (writes < 3 * pops - 8) begin
      errors++;
      $display("FAIL cont_write_share: got %0d expected >= %0d", writes, 3 * pops - 8);
    end
    bad_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!(mem_en === 1'b1 && mem_we === 1'b1 && wr_ready === 1'b1)) bad_done++;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    checks++;
    if (bad_done != 0) begin
      errors++;
      $display("FAIL done_no_reads: got %0d non-write cycles expected 0", bad_done);
    end
  endtask

  task automatic test_underrun;
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || pix !== 16'(TF - 1) || underrun !== 1'b0) begin
      errors++;
      $display("FAIL under_pre: got valid=%b pix=%h unr=%b expected 0 %h 0", pix_valid, pix, underrun, 16'(TF - 1));
    end
    @(posedge clk); #1;
    pix_rd = 1'b1;
    @(posedge clk); #1;
    pix_rd = 1'b0;
    @(negedge clk);
    checks++;
    if (underrun !== 1'b1 || pix !== 16'(TF - 1)) begin
      errors++;
      $display("FAIL under_set: got unr=%b pix=%h expected 1 %h", underrun, pix, 16'(TF - 1));
    end
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (underrun !== 1'b1 || pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL under_sticky: got unr=%b valid=%b expected 1 1", underrun, pix_valid);
    end
  endtask

  initial begin
    test_reset();
    test_idle_writes();
    test_fill();
    test_flush();
    test_contention();
    test_underrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
